// File: rtl/pc_run_monitor_if.sv
// Bus bundle for pc_run_monitor: run control, retire stream and stop table in;
// status, cause and run statistics out.
interface pc_run_monitor_if #(
  parameter int ADDR_SIZE = 32,
  parameter int NUM_STOP  = 4,
  parameter int CNT_W     = 32
);
  localparam int IDX_W = (NUM_STOP > 1) ? $clog2(NUM_STOP) : 1;

  logic                          start;
  logic                          clear;
  logic                          retire_valid;
  logic [ADDR_SIZE-1:0]          pc_w;
  logic [NUM_STOP*ADDR_SIZE-1:0] stop_addr;
  logic [NUM_STOP-1:0]           stop_en;

  logic                          running;
  logic                          done;
  logic                          done_pulse;
  logic [1:0]                    cause;
  logic [IDX_W-1:0]              hit_idx;
  logic [CNT_W-1:0]              cycle_cnt;
  logic [CNT_W-1:0]              retire_cnt;
  logic [ADDR_SIZE-1:0]          last_pc;

  modport master (
    output start, clear, retire_valid, pc_w, stop_addr, stop_en,
    input  running, done, done_pulse, cause, hit_idx, cycle_cnt, retire_cnt, last_pc
  );

  modport slave (
    input  start, clear, retire_valid, pc_w, stop_addr, stop_en,
    output running, done, done_pulse, cause, hit_idx, cycle_cnt, retire_cnt, last_pc
  );
endinterface

// File: rtl/pc_run_monitor.sv
// Watches the retire stream during a run and stops on a stop-address hit, a PC hang
// or a cycle timeout. Note: rstn is an active-HIGH asynchronous reset despite its name.

module pc_stop_cmp #(
  parameter int ADDR_SIZE = 32
) (
  input  logic                 en,
  input  logic                 valid,
  input  logic [ADDR_SIZE-1:0] pc,
  input  logic [ADDR_SIZE-1:0] addr,
  output logic                 hit
);
  assign hit = valid & en & (pc == addr);
endmodule

module pc_run_monitor #(
  parameter int ADDR_SIZE  = 32,
  parameter int NUM_STOP   = 4,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 100000,
  parameter int HANG_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rstn,
  pc_run_monitor_if.slave  bus
);
  localparam int IDX_W = (NUM_STOP > 1) ? $clog2(NUM_STOP) : 1;
  localparam int REP_W = (HANG_LIMIT > 1) ? $clog2(HANG_LIMIT + 1) : 1;
  localparam logic [REP_W-1:0] REP_LIM = REP_W'(HANG_LIMIT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_nxt;
  logic [CNT_W-1:0]     cycle_q, cycle_nxt;
  logic [CNT_W-1:0]     retire_q, retire_nxt;
  logic [ADDR_SIZE-1:0] last_q, last_nxt;
  logic [REP_W-1:0]     rep_q, rep_nxt;
  logic [1:0]           cause_q, cause_nxt;
  logic [IDX_W-1:0]     idx_q, idx_nxt;
  logic                 running_q, done_q, pulse_q;

  logic [NUM_STOP-1:0]  hit_vec;
  logic                 stop_hit;
  logic [IDX_W-1:0]     stop_idx;
  logic                 same_pc, hang_hit, to_hit;
  logic [REP_W-1:0]     rep_inc;

  for (genvar i = 0; i < NUM_STOP; i++) begin : g_cmp
    pc_stop_cmp #(.ADDR_SIZE(ADDR_SIZE)) u_cmp (
      .en   (bus.stop_en[i]),
      .valid(bus.retire_valid),
      .pc   (bus.pc_w),
      .addr (bus.stop_addr[i*ADDR_SIZE +: ADDR_SIZE]),
      .hit  (hit_vec[i])
    );
  end

  // Scan high to low so the lowest matching entry is the one left standing.
  always_comb begin
    stop_hit = 1'b0;
    stop_idx = '0;
    for (int i = NUM_STOP - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        stop_hit = 1'b1;
        stop_idx = IDX_W'(i);
      end
    end
  end

  assign same_pc  = bus.retire_valid && (bus.pc_w == last_q) && (retire_q != '0);
  assign rep_inc  = rep_q + 1'b1;
  assign hang_hit = (HANG_LIMIT != 0) && same_pc && (rep_inc == REP_LIM);
  assign to_hit   = (TIMEOUT != 0) && (cycle_q == TO_LAST);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    cycle_nxt  = cycle_q;
    retire_nxt = retire_q;
    last_nxt   = last_q;
    rep_nxt    = rep_q;
    cause_nxt  = cause_q;
    idx_nxt    = idx_q;
    if (bus.clear) begin
      state_nxt  = S_IDLE;
      cycle_nxt  = '0;
      retire_nxt = '0;
      last_nxt   = '0;
      rep_nxt    = '0;
      cause_nxt  = 2'b00;
      idx_nxt    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_nxt  = S_RUN;
            cycle_nxt  = '0;
            retire_nxt = '0;
            last_nxt   = '0;
            rep_nxt    = '0;
            cause_nxt  = 2'b00;
            idx_nxt    = '0;
          end
        end
        S_RUN: begin
          cycle_nxt = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
          if (bus.retire_valid) begin
            retire_nxt = (&retire_q) ? retire_q : retire_q + 1'b1;
            last_nxt   = bus.pc_w;
            rep_nxt    = same_pc ? rep_inc : '0;
          end
          if (stop_hit) begin
            state_nxt = S_DONE;
            cause_nxt = 2'b01;
            idx_nxt   = stop_idx;
          end else if (hang_hit) begin
            state_nxt = S_DONE;
            cause_nxt = 2'b10;
          end else if (to_hit) begin
            state_nxt = S_DONE;
            cause_nxt = 2'b11;
          end
        end
        S_DONE: ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Status flags decode the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cycle_q   <= '0;
      retire_q  <= '0;
      last_q    <= '0;
      rep_q     <= '0;
      cause_q   <= 2'b00;
      idx_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      cycle_q   <= cycle_nxt;
      retire_q  <= retire_nxt;
      last_q    <= last_nxt;
      rep_q     <= rep_nxt;
      cause_q   <= cause_nxt;
      idx_q     <= idx_nxt;
      running_q <= (state_nxt == S_RUN);
      done_q    <= (state_nxt == S_DONE);
      pulse_q   <= (state_nxt == S_DONE) && (state_q != S_DONE);
    end
  end

  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.done_pulse = pulse_q;
  assign bus.cause      = cause_q;
  assign bus.hit_idx    = idx_q;
  assign bus.cycle_cnt  = cycle_q;
  assign bus.retire_cnt = retire_q;
  assign bus.last_pc    = last_q;
endmodule
